// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//
// Purpose:
//   Instruction fetch unit forming the producer side of the IF/ID pipeline
//   register. It owns the program counter and keeps at most one request in
//   flight to instruction memory. It presents one instruction at a time to
//   if_id, holds it while if_id stalls, and handles redirects from EX.
//   A redirect that arrives while a fetch is in flight kills that fetch, and
//   the stale response is discarded when it returns.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   jmp, jmp_addr       redirect request and target from EX
//   if_id_stall         1 = if_id will not take the presented instruction
//   imem_req/imem_addr  one-cycle fetch strobe and fetch address (the PC)
//   imem_rdata/rvalid   returned instruction word and response strobe
//   inst_addr_from_if   PC of the presented instruction
//   inst_from_if        presented instruction (NOP_INST when not valid)
//   inst_valid          presented instruction is real
//   imem_err            one-cycle pulse when a fetch times out
// -----------------------------------------------------------------------------
module inst_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] NOP_INST    = 32'h0000_0013,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jmp,
  input  logic [31:0] jmp_addr,
  input  logic        if_id_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  output logic [31:0] inst_addr_from_if,
  output logic [31:0] inst_from_if,
  output logic        inst_valid,
  output logic        imem_err
);

  // Timeout counter is at least 5 bits wide, wider if TIMEOUT_CYC needs it.
  localparam int TMO_W = ($clog2(TIMEOUT_CYC) > 5) ? $clog2(TIMEOUT_CYC) : 5;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FULL,
    S_FLUSH
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      inst_q, inst_d;
  logic [31:0]      inst_addr_q, inst_addr_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  assign imem_req          = (state_q == S_REQ);
  assign imem_addr         = pc_q;
  assign inst_addr_from_if = inst_addr_q;
  assign inst_from_if      = inst_q;
  assign inst_valid        = valid_q;
  assign imem_err          = err_q;

  // Next-state logic. jmp is tested first in every state so a redirect always
  // wins over a stall or a response arriving on the same edge.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    inst_addr_d = inst_addr_q;
    valid_d     = valid_q;
    err_d       = 1'b0;
    tmo_d       = tmo_q;

    case (state_q)
      S_IDLE: begin
        if (jmp) begin
          pc_d = jmp_addr;
        end
        state_d = S_REQ;
      end

      S_REQ: begin
        // The request goes out this cycle; the wait/flush timer starts fresh.
        tmo_d = '0;
        if (jmp) begin
          pc_d    = jmp_addr;
          state_d = S_FLUSH;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        tmo_d = tmo_q + TMO_ONE;
        if (jmp) begin
          pc_d = jmp_addr;
          // A response on the same edge retires the killed fetch, so there is
          // nothing left to flush.
          if (imem_rvalid) begin
            state_d = S_REQ;
          end else begin
            tmo_d   = '0;
            state_d = S_FLUSH;
          end
        end else if (imem_rvalid) begin
          inst_d      = imem_rdata;
          inst_addr_d = pc_q;
          valid_d     = 1'b1;
          pc_d        = pc_q + 32'd4;
          state_d     = S_FULL;
        end else if (tmo_q >= TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_REQ;
        end
      end

      S_FULL: begin
        if (jmp) begin
          valid_d = 1'b0;
          inst_d  = NOP_INST;
          pc_d    = jmp_addr;
          state_d = S_REQ;
        end else if (!if_id_stall) begin
          valid_d = 1'b0;
          inst_d  = NOP_INST;
          state_d = S_REQ;
        end
      end

      S_FLUSH: begin
        tmo_d = tmo_q + TMO_ONE;
        if (jmp) begin
          pc_d = jmp_addr;
          if (imem_rvalid) begin
            state_d = S_REQ;
          end
        end else if (imem_rvalid) begin
          state_d = S_REQ;
        end else if (tmo_q >= TMO_LAST) begin
          // >= keeps the timeout reachable even if a late redirect pushed the
          // counter one past the limit.
          err_d   = 1'b1;
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset returns everything to the idle values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      inst_q      <= NOP_INST;
      inst_addr_q <= 32'h0000_0000;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      inst_addr_q <= inst_addr_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
//
// Self-checking bench for inst_fetch. A cycle-by-cycle vector table covers
// basic fetch and a stall. Hand-written sequences cover redirects, timeout,
// reset mid-fetch and PC wrap. A long randomized run follows.
//
// All phases are watched by a program-order reference model. The model tracks
// only the address of the next instruction the core should see. That address
// is the jump target after a redirect, or the consumed address + 4 otherwise.
// Every delivered instruction, every held instruction and every request
// address is judged against it.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] NOP_INST    = 32'h0000_0013;
  localparam int          TIMEOUT_CYC = 16;
  localparam int          NVEC        = 19;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        jmp = 1'b0;
  logic [31:0] jmp_addr = '0;
  logic        if_id_stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] inst_addr_from_if;
  logic [31:0] inst_from_if;
  logic        inst_valid;
  logic        imem_err;

  inst_fetch #(
    .RESET_PC   (RESET_PC),
    .NOP_INST   (NOP_INST),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .jmp              (jmp),
    .jmp_addr         (jmp_addr),
    .if_id_stall      (if_id_stall),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .imem_rvalid      (imem_rvalid),
    .inst_addr_from_if(inst_addr_from_if),
    .inst_from_if     (inst_from_if),
    .inst_valid       (inst_valid),
    .imem_err         (imem_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instruction memory behaviour: a single pending read that answers after mem_lat cycles.
  bit          mem_auto = 1'b0;
  bit          mem_drop = 1'b0;
  int          mem_lat = 1;
  bit          mem_pending = 1'b0;
  int          mem_left = 0;
  logic [31:0] mem_addr = '0;

  // Program-order reference model state.
  logic [31:0] exp_pc = RESET_PC;
  bit          prev_valid = 1'b0;
  bit          prev_stall = 1'b0;
  bit          prev_jmp = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_inst = '0;
  int          delivered = 0;

  typedef struct {
    logic        stall;
    logic        rvalid;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] iaddr;
    logic [31:0] inst;
  } vec_t;

  vec_t vecs[NVEC];

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  function automatic vec_t mk(input logic st, input logic rv, input logic [31:0] rd,
                              input logic rq, input logic [31:0] ad, input logic v,
                              input logic [31:0] ia, input logic [31:0] in);
    vec_t r;
    r.stall = st; r.rvalid = rv; r.rdata = rd; r.req = rq;
    r.addr = ad; r.valid = v; r.iaddr = ia; r.inst = in;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mem_pending = 1'b0;
    exp_pc      = RESET_PC;
    prev_valid  = 1'b0;
    prev_stall  = 1'b0;
    prev_jmp    = 1'b0;
    prev_addr   = '0;
    prev_inst   = '0;
  endtask

  task automatic modelCheck();
    if (!inst_valid) checkOutput("m_nop_when_invalid", inst_from_if, NOP_INST);
    if (prev_valid && prev_stall && !prev_jmp) begin
      checkBit("m_hold_valid", inst_valid, 1'b1);
      checkOutput("m_hold_addr", inst_addr_from_if, prev_addr);
      checkOutput("m_hold_inst", inst_from_if, prev_inst);
    end else if (prev_valid) begin
      checkBit("m_drop_after_take", inst_valid, 1'b0);
    end else if (inst_valid) begin
      checkOutput("m_deliver_addr", inst_addr_from_if, exp_pc);
      checkOutput("m_deliver_data", inst_from_if, memWord(inst_addr_from_if));
    end
    if (imem_req) checkOutput("m_req_addr", imem_addr, exp_pc);
  endtask

  // Called at posedge+2: drive one cycle's inputs, serve memory, then sample
  // at the falling edge and run the model checks.
  task automatic applyStimulus(input logic j, input logic [31:0] ja, input logic st);
    jmp = j;
    jmp_addr = ja;
    if_id_stall = st;
    if (mem_auto) begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (mem_pending) begin
        mem_left--;
        if (mem_left <= 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = memWord(mem_addr);
          mem_pending = 1'b0;
        end
      end
      if (imem_req) begin
        if (mem_pending) checkBit("m_one_outstanding", 1'b1, 1'b0);
        if (!mem_drop) begin
          mem_pending = 1'b1;
          mem_left    = mem_lat;
          mem_addr    = imem_addr;
        end
      end
    end
    @(negedge clk);
    modelCheck();
  endtask

  // Advance the model with this cycle's pre-edge values, then cross the edge.
  task automatic finishCycle();
    if (jmp) begin
      exp_pc = jmp_addr;
    end else if (inst_valid && !if_id_stall) begin
      exp_pc = inst_addr_from_if + 32'd4;
      delivered++;
    end
    prev_valid = inst_valid;
    prev_stall = if_id_stall;
    prev_jmp   = jmp;
    prev_addr  = inst_addr_from_if;
    prev_inst  = inst_from_if;
    @(posedge clk);
    #2;
  endtask

  task automatic setJmp(input logic [31:0] ja);
    jmp = 1'b1;
    jmp_addr = ja;
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    jmp = 1'b0;
    jmp_addr = '0;
    if_id_stall = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    modelReset();
  endtask

  task automatic runUntilValid(input string name, input int bound);
    int n = 0;
    applyStimulus(1'b0, 32'h0, 1'b0);
    while (!inst_valid && n < bound) begin
      finishCycle();
      applyStimulus(1'b0, 32'h0, 1'b0);
      n++;
    end
    checkBit({name, "_reached"}, inst_valid, 1'b1);
  endtask

  task automatic runUntilReq(input string name, input int bound);
    int n = 0;
    applyStimulus(1'b0, 32'h0, 1'b0);
    while (!imem_req && n < bound) begin
      finishCycle();
      applyStimulus(1'b0, 32'h0, 1'b0);
      n++;
    end
    checkBit({name, "_reached"}, imem_req, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic        rj;
    logic [31:0] rja;
    logic        rst;

    // Vector table: cycle k after reset release, 1-cycle memory, stall on 9..13.
    vecs[0]  = mk(0, 0, 0,              0, 32'd0,  0, 32'd0,  NOP_INST);
    vecs[1]  = mk(0, 0, 0,              1, 32'd0,  0, 32'd0,  NOP_INST);
    vecs[2]  = mk(0, 1, memWord(32'd0), 0, 32'd0,  0, 32'd0,  NOP_INST);
    vecs[3]  = mk(0, 0, 0,              0, 32'd4,  1, 32'd0,  memWord(32'd0));
    vecs[4]  = mk(0, 0, 0,              1, 32'd4,  0, 32'd0,  NOP_INST);
    vecs[5]  = mk(0, 1, memWord(32'd4), 0, 32'd4,  0, 32'd0,  NOP_INST);
    vecs[6]  = mk(0, 0, 0,              0, 32'd8,  1, 32'd4,  memWord(32'd4));
    vecs[7]  = mk(0, 0, 0,              1, 32'd8,  0, 32'd4,  NOP_INST);
    vecs[8]  = mk(0, 1, memWord(32'd8), 0, 32'd8,  0, 32'd4,  NOP_INST);
    for (int k = 9; k <= 13; k++)
      vecs[k] = mk(1, 0, 0,             0, 32'd12, 1, 32'd8,  memWord(32'd8));
    vecs[14] = mk(0, 0, 0,              0, 32'd12, 1, 32'd8,  memWord(32'd8));
    vecs[15] = mk(0, 0, 0,              1, 32'd12, 0, 32'd8,  NOP_INST);
    vecs[16] = mk(0, 1, memWord(32'd12),0, 32'd12, 0, 32'd8,  NOP_INST);
    vecs[17] = mk(0, 0, 0,              0, 32'd16, 1, 32'd12, memWord(32'd12));
    vecs[18] = mk(0, 0, 0,              1, 32'd16, 0, 32'd12, NOP_INST);

    $display("[TB] table: basic fetch and stall");
    mem_auto = 1'b0;
    resetDut();
    for (int k = 0; k < NVEC; k++) begin
      imem_rvalid = vecs[k].rvalid;
      imem_rdata  = vecs[k].rdata;
      applyStimulus(1'b0, 32'h0, vecs[k].stall);
      checkBit($sformatf("t1_req_c%0d", k), imem_req, vecs[k].req);
      checkOutput($sformatf("t1_addr_c%0d", k), imem_addr, vecs[k].addr);
      checkBit($sformatf("t1_valid_c%0d", k), inst_valid, vecs[k].valid);
      checkOutput($sformatf("t1_iaddr_c%0d", k), inst_addr_from_if, vecs[k].iaddr);
      checkOutput($sformatf("t1_inst_c%0d", k), inst_from_if, vecs[k].inst);
      checkBit($sformatf("t1_err_c%0d", k), imem_err, 1'b0);
      finishCycle();
    end
    imem_rvalid = 1'b0;

    $display("[TB] redirect while waiting, latency 3");
    mem_auto = 1'b1; mem_drop = 1'b0; mem_lat = 3;
    resetDut();
    runUntilReq("t3_req0", 5);
    checkOutput("t3_req0_addr", imem_addr, 32'h0);
    finishCycle();
    applyStimulus(1'b0, 32'h0, 1'b0);
    setJmp(32'h100);
    finishCycle();
    runUntilReq("t3_redirect", 10);
    checkOutput("t3_redirect_addr", imem_addr, 32'h100);
    checkBit("t3_no_stale_valid", inst_valid, 1'b0);
    finishCycle();
    runUntilValid("t3_deliver", 10);
    checkOutput("t3_deliver_addr", inst_addr_from_if, 32'h100);
    checkOutput("t3_deliver_data", inst_from_if, memWord(32'h100));
    finishCycle();

    $display("[TB] redirect with response, while full, while full and stalled");
    mem_lat = 1;
    resetDut();
    runUntilReq("t4a_req", 5);
    finishCycle();
    applyStimulus(1'b0, 32'h0, 1'b0);
    setJmp(32'h200);
    finishCycle();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkBit("t4a_valid", inst_valid, 1'b0);
    checkBit("t4a_req", imem_req, 1'b1);
    checkOutput("t4a_addr", imem_addr, 32'h200);
    finishCycle();
    runUntilValid("t4b", 10);
    checkOutput("t4b_iaddr", inst_addr_from_if, 32'h200);
    setJmp(32'h300);
    finishCycle();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkBit("t4b_valid", inst_valid, 1'b0);
    checkBit("t4b_req", imem_req, 1'b1);
    checkOutput("t4b_addr", imem_addr, 32'h300);
    finishCycle();
    runUntilValid("t4c", 10);
    if_id_stall = 1'b1;
    finishCycle();
    repeat (2) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkBit("t4c_req_held", imem_req, 1'b0);
      finishCycle();
    end
    applyStimulus(1'b0, 32'h0, 1'b1);
    setJmp(32'h400);
    finishCycle();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkBit("t4c_valid", inst_valid, 1'b0);
    checkBit("t4c_req", imem_req, 1'b1);
    checkOutput("t4c_addr", imem_addr, 32'h400);
    finishCycle();

    $display("[TB] fetch timeout at 0x20");
    resetDut();
    runUntilValid("t5_first", 10);
    setJmp(32'h20);
    finishCycle();
    mem_drop = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkBit("t5_req", imem_req, 1'b1);
    checkOutput("t5_req_addr", imem_addr, 32'h20);
    finishCycle();
    for (int k = 1; k <= TIMEOUT_CYC; k++) begin
      applyStimulus(1'b0, 32'h0, 1'b0);
      checkBit($sformatf("t5_no_err_%0d", k), imem_err, 1'b0);
      checkBit($sformatf("t5_no_req_%0d", k), imem_req, 1'b0);
      finishCycle();
    end
    mem_drop = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkBit("t5_err_pulse", imem_err, 1'b1);
    checkBit("t5_rereq", imem_req, 1'b1);
    checkOutput("t5_rereq_addr", imem_addr, 32'h20);
    finishCycle();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkBit("t5_err_one_cycle", imem_err, 1'b0);
    finishCycle();
    runUntilValid("t5_retry", 10);
    checkOutput("t5_retry_addr", inst_addr_from_if, 32'h20);
    finishCycle();

    $display("[TB] reset while waiting");
    mem_lat = 3;
    resetDut();
    runUntilValid("t6_first", 12);
    setJmp(32'h40);
    finishCycle();
    runUntilValid("t6_at40", 12);
    checkOutput("t6_at40_iaddr", inst_addr_from_if, 32'h40);
    finishCycle();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t6_req44", imem_addr, 32'h44);
    finishCycle();
    applyStimulus(1'b0, 32'h0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    checkBit("t6_rst_valid", inst_valid, 1'b0);
    checkOutput("t6_rst_inst", inst_from_if, NOP_INST);
    checkOutput("t6_rst_iaddr", inst_addr_from_if, 32'h0);
    checkBit("t6_rst_req", imem_req, 1'b0);
    checkBit("t6_rst_err", imem_err, 1'b0);
    checkOutput("t6_rst_pc", imem_addr, RESET_PC);
    @(posedge clk);
    #2 rst_n = 1'b1;
    modelReset();
    mem_auto = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = memWord(32'h44);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkBit("t6_idle_ignores_resp", inst_valid, 1'b0);
    finishCycle();
    mem_auto = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkBit("t6_first_req", imem_req, 1'b1);
    checkOutput("t6_first_req_addr", imem_addr, RESET_PC);
    finishCycle();
    runUntilValid("t6_deliver", 12);
    checkOutput("t6_deliver_addr", inst_addr_from_if, RESET_PC);
    finishCycle();

    $display("[TB] pc wrap");
    mem_lat = 1;
    resetDut();
    runUntilValid("t7_first", 10);
    setJmp(32'hFFFF_FFFC);
    finishCycle();
    runUntilValid("t7_top", 10);
    checkOutput("t7_top_addr", inst_addr_from_if, 32'hFFFF_FFFC);
    finishCycle();
    runUntilReq("t7_wrap", 10);
    checkOutput("t7_wrap_addr", imem_addr, 32'h0);
    finishCycle();

    $display("[TB] randomized run");
    resetDut();
    delivered = 0;
    for (int i = 0; i < 3000; i++) begin
      mem_lat = $urandom_range(1, 5);
      rj  = (i > 2) && ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0:       rja = 32'hFFFF_FFF8;
        1:       rja = 32'hFFFF_FFF0;
        default: rja = $urandom & 32'hFFFF_FFFC;
      endcase
      rst = ($urandom_range(0, 2) == 0);
      applyStimulus(rj, rja, rst);
      checkBit("r_no_err", imem_err, 1'b0);
      finishCycle();
    end
    checkBit("r_progress", delivered >= 100, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
